// File: rtl/ins_fetch_queue.sv
// Instruction fetch with PC ownership, fixed-latency IM reads and a prefetch queue.
// Redirects flush queued words; an epoch bit discards reads issued before a redirect.
module ins_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_3000,
    parameter int              CNT_W    = 16,
    localparam int             AW       = $clog2(DEPTH),
    localparam int             CW       = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             im_req,
    output logic [XLEN-1:0]  im_addr,
    input  logic [31:0]      im_rdata,
    input  logic             br_valid,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [15:0]      br_imm16,
    input  logic             alu_zero,
    input  logic             jmp_valid,
    input  logic [XLEN-1:0]  jmp_pc,
    input  logic [25:0]      jmp_imm26,
    output logic             ins_valid,
    input  logic             ins_ready,
    output logic [31:0]      ins_data,
    output logic [XLEN-1:0]  ins_pc,
    output logic [CW-1:0]    q_count,
    output logic [CNT_W-1:0] redir_cnt
);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [XLEN-1:0]  infl_pc_q, infl_pc_d;
    logic             infl_epoch_q, infl_epoch_d;
    logic             epoch_q, epoch_d;
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
    logic [31:0]      hold_data_q, hold_data_d;
    logic [XLEN-1:0]  hold_pc_q, hold_pc_d;
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [XLEN-1:0]  pc_q [DEPTH];
    logic [XLEN-1:0]  pc_d [DEPTH];

    logic            br_take;
    logic            redir;
    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] jpc4;
    logic [XLEN-1:0] jmp_tgt;
    logic [XLEN-1:0] target;
    logic            push;
    logic            pop;
    logic            not_empty;

    always_comb begin
        br_take = br_valid & alu_zero;
        redir   = jmp_valid | br_take;
        br_off  = {{(XLEN-18){br_imm16[15]}}, br_imm16, 2'b00};
        jpc4    = jmp_pc + XLEN'(4);
        jmp_tgt = jpc4;
        jmp_tgt[31:0] = {jpc4[31:28], jmp_imm26, 2'b00};
        target  = jmp_valid ? jmp_tgt : br_pc + XLEN'(4) + br_off;
    end

    // Credit check counts the in-flight read so a return always has a slot.
    assign im_req    = rst_n & ~redir &
                       ((count_q + CW'(inflight_q)) < CW'(DEPTH));
    assign im_addr   = fetch_pc_q;
    assign not_empty = (count_q != '0);
    assign ins_valid = not_empty & ~redir;
    assign pop       = ins_valid & ins_ready;
    assign push      = inflight_q & (infl_epoch_q == epoch_q) & ~redir;
    assign ins_data  = not_empty ? data_q[head_q] : hold_data_q;
    assign ins_pc    = not_empty ? pc_q[head_q] : hold_pc_q;
    assign q_count   = count_q;
    assign redir_cnt = redir_cnt_q;

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        inflight_d   = im_req;
        infl_pc_d    = infl_pc_q;
        infl_epoch_d = epoch_q;
        epoch_d      = epoch_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        redir_cnt_d  = redir_cnt_q;
        hold_data_d  = hold_data_q;
        hold_pc_d    = hold_pc_q;
        data_d       = data_q;
        pc_d         = pc_q;
        if (im_req) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            infl_pc_d  = fetch_pc_q;
        end
        if (redir) begin
            fetch_pc_d = target;
            epoch_d    = ~epoch_q;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            if (redir_cnt_q != '1)
                redir_cnt_d = redir_cnt_q + CNT_W'(1);
        end else begin
            if (push) begin
                data_d[tail_q] = im_rdata;
                pc_d[tail_q]   = infl_pc_q;
                tail_d         = tail_q + AW'(1);
            end
            if (pop) begin
                hold_data_d = data_q[head_q];
                hold_pc_d   = pc_q[head_q];
                head_d      = head_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q   <= RESET_PC;
            inflight_q   <= 1'b0;
            infl_pc_q    <= '0;
            infl_epoch_q <= 1'b0;
            epoch_q      <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            redir_cnt_q  <= '0;
            hold_data_q  <= '0;
            hold_pc_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            inflight_q   <= inflight_d;
            infl_pc_q    <= infl_pc_d;
            infl_epoch_q <= infl_epoch_d;
            epoch_q      <= epoch_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            redir_cnt_q  <= redir_cnt_d;
            hold_data_q  <= hold_data_d;
            hold_pc_q    <= hold_pc_d;
            data_q       <= data_d;
            pc_q         <= pc_d;
        end
    end

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Directed bench for ins_fetch_queue: reset, backpressure, redirect table, wrap, mid-run reset.
// A behavioural IM returns a PC-derived word one cycle after each request.
module tb_ins_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        im_req;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        br_valid;
    logic [31:0] br_pc;
    logic [15:0] br_imm16;
    logic        alu_zero;
    logic        jmp_valid;
    logic [31:0] jmp_pc;
    logic [25:0] jmp_imm26;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic [2:0]  q_count;
    logic [15:0] redir_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] acc[$];

    typedef struct {
        logic        bv;
        logic [31:0] bpc;
        logic [15:0] bimm;
        logic        az;
        logic        jv;
        logic [31:0] jpc;
        logic [25:0] jimm;
        logic        seq;
        logic [31:0] exp_pc;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[6];

    ins_fetch_queue dut (
        .clk(clk), .rst_n(rst_n),
        .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata),
        .br_valid(br_valid), .br_pc(br_pc), .br_imm16(br_imm16),
        .alu_zero(alu_zero), .jmp_valid(jmp_valid), .jmp_pc(jmp_pc),
        .jmp_imm26(jmp_imm26), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_data(ins_data), .ins_pc(ins_pc), .q_count(q_count),
        .redir_cnt(redir_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imf(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    always @(posedge clk)
        im_rdata <= im_req ? imf(im_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && ins_valid && ins_ready) begin
            acc.push_back(ins_pc);
            chk("data", ins_data, imf(ins_pc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n, input int limit);
        for (int i = 0; i < limit && acc.size() < n; i++)
            tick();
        checks++;
        if (acc.size() < n) begin
            errors++;
            $display("FAIL timeout got %0d want %0d", acc.size(), n);
            while (acc.size() < n) acc.push_back(32'hX);
        end
    endtask

    task automatic clr_redir();
        br_valid  = 0; br_pc = 0; br_imm16 = 0; alu_zero = 0;
        jmp_valid = 0; jmp_pc = 0; jmp_imm26 = 0;
    endtask

    task automatic do_reset(input logic rdy);
        rst_n = 0;
        ins_ready = rdy;
        clr_redir();
        repeat (3) tick();
        rst_n = 1;
        acc.delete();
    endtask

    initial begin
        logic [31:0] last;
        logic [31:0] e;
        vecs[0] = '{1, 32'h3008, 16'h0004, 1, 0, 0, 0, 0, 32'h301C, 1};
        vecs[1] = '{1, 32'h3008, 16'h0004, 0, 0, 0, 0, 1, 0, 1};
        vecs[2] = '{0, 0, 0, 0, 1, 32'h3010, 26'hC10, 0, 32'h3040, 2};
        vecs[3] = '{1, 32'h3008, 16'h0004, 1, 1, 32'h3010, 26'hC10, 0, 32'h3040, 3};
        vecs[4] = '{1, 32'h3020, 16'hFFFE, 1, 0, 0, 0, 0, 32'h301C, 4};
        vecs[5] = '{1, 32'hFFFF_FFF0, 16'h0002, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 5};

        // Reset values and first-fetch latency
        rst_n = 0;
        ins_ready = 1;
        clr_redir();
        repeat (3) tick();
        @(negedge clk);
        chk("rst_addr", im_addr, 32'h3000);
        chk("rst_req", 32'(im_req), 0);
        chk("rst_valid", 32'(ins_valid), 0);
        chk("rst_data", ins_data, 0);
        chk("rst_pc", ins_pc, 0);
        chk("rst_cnt", 32'(q_count), 0);
        chk("rst_redir", 32'(redir_cnt), 0);
        tick();
        rst_n = 1;
        acc.delete();
        @(negedge clk);
        chk("lat_req0", 32'(im_req), 1);
        chk("lat_val0", 32'(ins_valid), 0);
        @(negedge clk);
        chk("lat_val1", 32'(ins_valid), 0);
        @(negedge clk);
        chk("lat_val2", 32'(ins_valid), 1);
        @(negedge clk);
        @(negedge clk);
        tick();
        chk("tput_n", 32'(acc.size()), 3);
        wait_acc(3, 10);
        for (int i = 0; i < 3; i++)
            chk("seq_pc", acc[i], 32'h3000 + 32'(4 * i));

        // Backpressure fills the queue, then drains in order
        do_reset(0);
        repeat (10) tick();
        @(negedge clk);
        chk("full_cnt", 32'(q_count), 4);
        chk("full_req", 32'(im_req), 0);
        chk("hold_pc", ins_pc, 32'h3000);
        tick();
        ins_ready = 1;
        wait_acc(6, 20);
        for (int i = 0; i < 6; i++)
            chk("drain_pc", acc[i], 32'h3000 + 32'(4 * i));

        // Redirect table
        do_reset(1);
        repeat (8) tick();
        foreach (vecs[k]) begin
            repeat (3) tick();
            last = acc[acc.size() - 1];
            e = vecs[k].seq ? last + 32'd4 : vecs[k].exp_pc;
            acc.delete();
            br_valid  = vecs[k].bv;   br_pc  = vecs[k].bpc;
            br_imm16  = vecs[k].bimm; alu_zero = vecs[k].az;
            jmp_valid = vecs[k].jv;   jmp_pc = vecs[k].jpc;
            jmp_imm26 = vecs[k].jimm;
            @(negedge clk);
            if (!vecs[k].seq) begin
                chk("redir_valid", 32'(ins_valid), 0);
                chk("redir_req", 32'(im_req), 0);
            end
            tick();
            clr_redir();
            wait_acc(3, 20);
            for (int i = 0; i < 3; i++)
                chk($sformatf("vec%0d_pc%0d", k, i), acc[i], e + 32'(4 * i));
            chk($sformatf("vec%0d_cnt", k), 32'(redir_cnt), 32'(vecs[k].exp_cnt));
        end

        // Reset while a read is in flight with a nearly full queue
        do_reset(0);
        repeat (10) tick();
        ins_ready = 1;
        tick();
        ins_ready = 0;
        @(negedge clk);
        chk("pre_cnt", 32'(q_count), 3);
        tick();
        #1;
        rst_n = 0;
        #1;
        chk("mid_cnt", 32'(q_count), 0);
        chk("mid_valid", 32'(ins_valid), 0);
        chk("mid_redir", 32'(redir_cnt), 0);
        @(negedge clk);
        chk("mid_cnt2", 32'(q_count), 0);
        tick();
        tick();
        rst_n = 1;
        acc.delete();
        ins_ready = 1;
        wait_acc(2, 20);
        chk("restart0", acc[0], 32'h3000);
        chk("restart1", acc[1], 32'h3004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
